instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Sequential fetch front end sitting directly upstream of the instruction decode/control stage.
- Owns the program counter and issues word-aligned read requests to a handshaked instruction memory.
- Buffers returned instructions with their PC in a small prefetch queue, and hands them downstream over a valid/ready interface.
- A taken branch from execute redirects it: stale in-flight responses and queued instructions are discarded.

Parameters:
- ADDRESS_WIDTH, 64, PC and memory address width.
- INSTRUCTION_WIDTH, 32, instruction word width.
- QUEUE_DEPTH, 4, prefetch queue entries; power of two, at least 2.
- RESET_VECTOR, 64'h0, PC loaded on reset.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- redirect_valid  in  1  taken-branch pulse from execute.
- redirect_address  in  ADDRESS_WIDTH  branch target; bits [1:0] are ignored and forced to 0.
- imem_request_valid  out  1  read request valid.
- imem_request_ready  in  1  memory accepts the request.
- imem_request_address  out  ADDRESS_WIDTH  word-aligned fetch address.
- imem_response_valid  in  1  read data valid; responses return in order, at least 1 cycle after acceptance.
- imem_response_data  in  INSTRUCTION_WIDTH  returned instruction.
- instruction_valid  out  1  queue head valid.
- instruction_ready  in  1  decode accepts the head.
- instruction  out  INSTRUCTION_WIDTH  head instruction.
- instruction_pc  out  ADDRESS_WIDTH  PC of the head instruction.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=BOOT; fetch_pc=response_pc=RESET_VECTOR.
  - outstanding=0, drop_count=0, queue empty.
  - imem_request_valid=0, instruction_valid=0, instruction=0, instruction_pc=0.
  - Reset mid-operation abandons everything; responses arriving after reset are ignored until a new request is accepted.
- States:
  - BOOT: lasts 1 cycle, then RUN.
  - RUN: normal fetch.
  - FLUSH: discarding stale responses.
- Request issue (RUN only):
  - Assert imem_request_valid with imem_request_address=fetch_pc when outstanding + queue_count < QUEUE_DEPTH. This credit rule guarantees every response has a slot.
  - Once asserted, valid and address are held stable until valid&&ready, including across a redirect.
  - On handshake: fetch_pc += 4, modulo 2^ADDRESS_WIDTH (wrap from all-ones-minus-3 to 0); outstanding++.
- Response (not dropping):
  - Push {response_pc, imem_response_data} into the queue; response_pc += 4; outstanding--.
  - The queue is registered: a response in cycle N gives instruction_valid at N+1 at the earliest. There is no bypass.
- Output:
  - instruction/instruction_pc show the queue head while instruction_valid=1.
  - Pop on instruction_valid&&instruction_ready.
  - A push and a pop in the same cycle keep queue_count unchanged; this is legal even when the queue is full.
- Redirect (any state except BOOT):
  - Queue cleared at the edge. A head popped in the same cycle counts as delivered.
  - drop_count = outstanding at the next edge, i.e. including a request accepted this cycle and excluding a response arriving this cycle.
  - A response arriving in the redirect cycle is discarded.
  - fetch_pc = response_pc = aligned redirect_address.
  - Next state is FLUSH if drop_count>0, else RUN.
- FLUSH:
  - No new requests; the pending held request still completes and is included in drop_count.
  - Each response decrements drop_count and outstanding, with no push.
  - Go to RUN when drop_count reaches 0.
  - A redirect during FLUSH replaces the target; drop_count is recomputed as outstanding.
- Response with outstanding==0 (protocol violation): ignored; flagged by assertion.
- A redirect asserted during BOOT is ignored.

Decomposition:
- Shared package fetch_pkg:
  - Width constants: ADDRESS_WIDTH, INSTRUCTION_WIDTH.
  - State encoding: BOOT=2'd0, RUN=2'd1, FLUSH=2'd2.
  - Queue entry layout: {pc, instruction}.
  - PC increment constant 4.
- One sub-module: fetch_queue.
  - Synchronous FIFO of QUEUE_DEPTH entries with push, pop, clear, count, full/empty.
  - Clear has priority over push.

Test Plan:
- Reset release, memory always ready, 1-cycle latency:
  - Requests at 0x0, 0x4, 0x8, 0xC.
  - First instruction_valid 3 cycles after reset deasserts, with instruction_pc=0x0.
  - In-order PCs follow.
- instruction_ready held 0:
  - Exactly 4 requests issued, then imem_request_valid stays 0.
  - After one pop, exactly one new request, to 0x10.
- imem_request_ready low for 3 cycles with redirect to 0x103 in cycle 2:
  - Address stays 0x0 until accepted.
  - That response is dropped; next request is 0x100.
  - First delivered instruction_pc=0x100.
- 3 requests outstanding with 4-cycle latency, redirect to 0x200:
  - FLUSH drops exactly 3 responses; queue emptied.
  - instruction_valid low until the 0x200 instruction returns.
- Simultaneous redirect and response arrival:
  - Response discarded.
  - Redirect while in FLUSH to 0x300: only 0x300-stream instructions delivered.
- fetch_pc at 0xFFFF_FFFF_FFFF_FFFC:
  - Next request address wraps to 0x0.
  - Reset asserted mid-FLUSH returns all outputs to reset values in the next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
package fetch_pkg;

    localparam int unsigned ADDRESS_WIDTH     = 64;
    localparam int unsigned INSTRUCTION_WIDTH = 32;
    localparam int unsigned PC_INCREMENT      = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    // Prefetch queue entry: PC in the upper bits, instruction in the lower bits.
    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0]     pc;
        logic [INSTRUCTION_WIDTH-1:0] instruction;
    } queue_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO; clear wins over push, push on a full queue is legal only with a pop.
module fetch_queue
#(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4
)
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    read_ptr;
    logic [PW-1:0]    write_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = storage[read_ptr];

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            read_ptr  <= '0;
            write_ptr <= '0;
            count     <= '0;
        end else begin
            if (do_push) begin
                write_ptr <= write_ptr + PW'(1);
            end
            if (do_pop) begin
                read_ptr <= read_ptr + PW'(1);
            end
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !clear) begin
            storage[write_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential fetch front end: owns the PC, issues credited memory reads, queues returned
// instructions with their PC, and discards stale responses after a taken-branch redirect.
module instruction_fetch_unit
#(
    parameter int unsigned                          ADDRESS_WIDTH     = fetch_pkg::ADDRESS_WIDTH,
    parameter int unsigned                          INSTRUCTION_WIDTH = fetch_pkg::INSTRUCTION_WIDTH,
    parameter int unsigned                          QUEUE_DEPTH       = 4,
    parameter logic [ADDRESS_WIDTH-1:0]             RESET_VECTOR      = '0
)
(
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0]     redirect_address,
    output logic                         imem_request_valid,
    input  logic                         imem_request_ready,
    output logic [ADDRESS_WIDTH-1:0]     imem_request_address,
    input  logic                         imem_response_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_response_data,
    output logic                         instruction_valid,
    input  logic                         instruction_ready,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [ADDRESS_WIDTH-1:0]     instruction_pc
);

    import fetch_pkg::*;

    localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned EW = ADDRESS_WIDTH + INSTRUCTION_WIDTH;

    fetch_state_t             state;
    fetch_state_t             state_next;
    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_next;
    logic [ADDRESS_WIDTH-1:0] response_pc;
    logic [ADDRESS_WIDTH-1:0] response_pc_next;
    logic [ADDRESS_WIDTH-1:0] held_address;
    logic [ADDRESS_WIDTH-1:0] target;
    logic                     held;
    logic                     held_next;
    logic [CW-1:0]            outstanding;
    logic [CW-1:0]            outstanding_next;
    logic [CW-1:0]            drop_count;
    logic [CW-1:0]            drop_next;
    logic [CW-1:0]            queue_count;
    logic                     queue_full;
    logic                     queue_empty;
    logic [EW-1:0]            queue_head;
    logic                     redirect;
    logic                     credit_ok;
    logic                     request_fire;
    logic                     response_fire;
    logic                     push;
    logic                     pop;

    assign redirect      = redirect_valid && (state != BOOT);
    assign target        = redirect_address & ~(ADDRESS_WIDTH'(3));
    assign credit_ok     = ({1'b0, outstanding} + {1'b0, queue_count}) < (CW+1)'(QUEUE_DEPTH);

    // A shown-but-unaccepted request keeps its address even after a redirect moves fetch_pc.
    assign imem_request_valid   = held || ((state == RUN) && credit_ok);
    assign imem_request_address = held ? held_address : fetch_pc;

    assign request_fire     = imem_request_valid && imem_request_ready;
    assign response_fire    = imem_response_valid && (outstanding != '0);
    assign held_next        = imem_request_valid && !imem_request_ready;
    assign outstanding_next = outstanding + CW'(request_fire) - CW'(response_fire);
    assign push             = response_fire && (state == RUN) && !redirect;
    assign pop              = instruction_valid && instruction_ready;

    assign instruction_valid = !queue_empty;
    assign instruction       = queue_empty ? '0 : queue_head[INSTRUCTION_WIDTH-1:0];
    assign instruction_pc    = queue_empty ? '0 : queue_head[EW-1:INSTRUCTION_WIDTH];

    always_comb begin
        state_next       = state;
        drop_next        = drop_count;
        fetch_pc_next    = fetch_pc;
        response_pc_next = response_pc;
        unique case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (request_fire) begin
                    fetch_pc_next = fetch_pc + ADDRESS_WIDTH'(PC_INCREMENT);
                end
                if (push) begin
                    response_pc_next = response_pc + ADDRESS_WIDTH'(PC_INCREMENT);
                end
            end
            FLUSH: begin
                if (response_fire) begin
                    drop_next = drop_count - CW'(1);
                end
                if (drop_next == '0) begin
                    state_next = RUN;
                end
            end
            default: state_next = BOOT;
        endcase
        // A still-held request is already doomed, so it is counted as a response to drop.
        if (redirect) begin
            drop_next        = outstanding_next + CW'(held_next);
            fetch_pc_next    = target;
            response_pc_next = target;
            state_next       = (drop_next != '0) ? FLUSH : RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= BOOT;
            fetch_pc     <= RESET_VECTOR;
            response_pc  <= RESET_VECTOR;
            outstanding  <= '0;
            drop_count   <= '0;
            held         <= 1'b0;
            held_address <= '0;
        end else begin
            state        <= state_next;
            fetch_pc     <= fetch_pc_next;
            response_pc  <= response_pc_next;
            outstanding  <= outstanding_next;
            drop_count   <= drop_next;
            held         <= held_next;
            held_address <= imem_request_address;
        end
    end

    fetch_queue #(
        .WIDTH (EW),
        .DEPTH (QUEUE_DEPTH)
    ) queue (
        .clock     (clock),
        .reset     (reset),
        .clear     (redirect),
        .push      (push),
        .push_data ({response_pc, imem_response_data}),
        .pop       (pop),
        .head      (queue_head),
        .count     (queue_count),
        .full      (queue_full),
        .empty     (queue_empty)
    );

    response_has_request: assert property (@(posedge clock) disable iff (!reset)
        imem_response_valid |-> (outstanding != '0));

    push_has_slot: assert property (@(posedge clock) disable iff (!reset)
        push |-> (!queue_full || pop));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with an in-order, per-request-latency memory model.
module tb_instruction_fetch_unit;

    logic        clock;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_address;
    logic        imem_request_valid;
    logic        imem_request_ready;
    logic [63:0] imem_request_address;
    logic        imem_response_valid;
    logic [31:0] imem_response_data;
    logic        instruction_valid;
    logic        instruction_ready;
    logic [31:0] instruction;
    logic [63:0] instruction_pc;

    typedef struct {
        logic [63:0] addr;
        int unsigned due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    logic [63:0] acc_q[$];
    logic [63:0] deliv_q[$];
    logic [63:0] deliv_inst_q[$];
    int unsigned mem_latency;
    int unsigned cyc;
    int          rsp_count;
    int          assertion_count;
    int          failure_count;

    instruction_fetch_unit #(
        .ADDRESS_WIDTH     (64),
        .INSTRUCTION_WIDTH (32),
        .QUEUE_DEPTH       (4),
        .RESET_VECTOR      (64'h0)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .redirect_valid       (redirect_valid),
        .redirect_address     (redirect_address),
        .imem_request_valid   (imem_request_valid),
        .imem_request_ready   (imem_request_ready),
        .imem_request_address (imem_request_address),
        .imem_response_valid  (imem_response_valid),
        .imem_response_data   (imem_response_data),
        .instruction_valid    (instruction_valid),
        .instruction_ready    (instruction_ready),
        .instruction          (instruction),
        .instruction_pc       (instruction_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertion_count++;
        if (actual !== expected) begin
            failure_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [63:0] pick(input logic [63:0] q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return '1;
    endfunction

    // Sample the cycle just before the edge, advance one clock, then update the memory model.
    task automatic tick();
        logic        rst;
        logic        hs;
        logic        rsp;
        logic        dlv;
        logic [63:0] a;
        logic [63:0] dpc;
        logic [31:0] dinst;
        #1;
        rst   = reset;
        hs    = imem_request_valid && imem_request_ready;
        a     = imem_request_address;
        rsp   = imem_response_valid;
        dlv   = instruction_valid && instruction_ready;
        dpc   = instruction_pc;
        dinst = instruction;
        @(posedge clock);
        #1;
        if (!rst) begin
            mem_q.delete();
        end else begin
            if (rsp && mem_q.size() > 0) begin
                void'(mem_q.pop_front());
                rsp_count++;
            end
            if (hs) begin
                acc_q.push_back(a);
                mem_q.push_back('{addr: a, due: cyc + mem_latency});
            end
            if (dlv) begin
                deliv_q.push_back(dpc);
                deliv_inst_q.push_back(64'(dinst));
            end
        end
        cyc++;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_response_valid = 1'b1;
            imem_response_data  = 32'hC0DE_0000 | {16'h0, mem_q[0].addr[15:0]};
        end else begin
            imem_response_valid = 1'b0;
            imem_response_data  = '0;
        end
    endtask

    task automatic do_reset(input string tag);
        reset              = 1'b0;
        redirect_valid     = 1'b0;
        redirect_address   = '0;
        instruction_ready  = 1'b0;
        imem_request_ready = 1'b0;
        mem_latency        = 1;
        tick();
        tick();
        check_value({tag, "_rst_req_valid"}, 64'(imem_request_valid), 64'h0);
        check_value({tag, "_rst_ivalid"},    64'(instruction_valid),  64'h0);
        check_value({tag, "_rst_inst"},      64'(instruction),        64'h0);
        check_value({tag, "_rst_pc"},        instruction_pc,          64'h0);
        acc_q.delete();
        deliv_q.delete();
        deliv_inst_q.delete();
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  r0;
        bit  early_valid;
        assertion_count     = 0;
        failure_count       = 0;
        cyc                 = 0;
        rsp_count           = 0;
        imem_response_valid = 1'b0;
        imem_response_data  = '0;

        // Streaming after reset with 1-cycle memory latency.
        do_reset("t1");
        imem_request_ready = 1'b1;
        instruction_ready  = 1'b1;
        tick();
        check_value("t1_req_valid", 64'(imem_request_valid), 64'h1);
        check_value("t1_req_addr",  imem_request_address,    64'h0);
        check_value("t1_ivalid_c1", 64'(instruction_valid),  64'h0);
        tick();
        check_value("t1_ivalid_c2", 64'(instruction_valid),  64'h0);
        tick();
        check_value("t1_ivalid_c3", 64'(instruction_valid),  64'h1);
        check_value("t1_first_pc",  instruction_pc,          64'h0);
        check_value("t1_first_inst", 64'(instruction),       64'hC0DE_0000);
        repeat (6) tick();
        check_value("t1_acc0", pick(acc_q, 0), 64'h0);
        check_value("t1_acc1", pick(acc_q, 1), 64'h4);
        check_value("t1_acc2", pick(acc_q, 2), 64'h8);
        check_value("t1_acc3", pick(acc_q, 3), 64'hC);
        check_value("t1_dlv1", pick(deliv_q, 1), 64'h4);
        check_value("t1_dlv3", pick(deliv_q, 3), 64'hC);
        check_value("t1_dlv3_inst", pick(deliv_inst_q, 3), 64'hC0DE_000C);

        // Decode stalled: credit limits fetch to the queue depth.
        do_reset("t2");
        imem_request_ready = 1'b1;
        repeat (12) tick();
        check_value("t2_acc_count", 64'(acc_q.size()),       64'd4);
        check_value("t2_req_idle",  64'(imem_request_valid), 64'h0);
        check_value("t2_head_pc",   instruction_pc,          64'h0);
        instruction_ready = 1'b1;
        tick();
        instruction_ready = 1'b0;
        check_value("t2_head_after_pop", instruction_pc,          64'h4);
        check_value("t2_req_again",      64'(imem_request_valid), 64'h1);
        check_value("t2_req_addr",       imem_request_address,    64'h10);
        repeat (8) tick();
        check_value("t2_acc_count2", 64'(acc_q.size()),       64'd5);
        check_value("t2_acc4",       pick(acc_q, 4),          64'h10);
        check_value("t2_req_idle2",  64'(imem_request_valid), 64'h0);

        // Redirect while a request is held by a stalled memory.
        do_reset("t3");
        instruction_ready = 1'b1;
        tick();
        check_value("t3_hold_c1", imem_request_address, 64'h0);
        tick();
        redirect_valid   = 1'b1;
        redirect_address = 64'h103;
        tick();
        redirect_valid = 1'b0;
        check_value("t3_hold_valid", 64'(imem_request_valid), 64'h1);
        check_value("t3_hold_c3",    imem_request_address,    64'h0);
        tick();
        check_value("t3_hold_c4",    imem_request_address,    64'h0);
        imem_request_ready = 1'b1;
        tick();
        check_value("t3_flush_idle", 64'(imem_request_valid), 64'h0);
        tick();
        check_value("t3_new_valid",  64'(imem_request_valid), 64'h1);
        check_value("t3_new_addr",   imem_request_address,    64'h100);
        repeat (4) tick();
        check_value("t3_first_dlv",  pick(deliv_q, 0), 64'h100);
        check_value("t3_first_inst", pick(deliv_inst_q, 0), 64'hC0DE_0100);

        // Three responses in flight when the branch arrives.
        do_reset("t4");
        imem_request_ready = 1'b1;
        tick();
        tick();
        mem_latency = 4;
        tick();
        tick();
        tick();
        check_value("t4_acc_count",   64'(acc_q.size()),       64'd4);
        check_value("t4_credit_idle", 64'(imem_request_valid), 64'h0);
        check_value("t4_queued",      64'(instruction_valid),  64'h1);
        redirect_valid   = 1'b1;
        redirect_address = 64'h200;
        tick();
        redirect_valid = 1'b0;
        r0 = rsp_count;
        check_value("t4_queue_cleared", 64'(instruction_valid), 64'h0);
        instruction_ready = 1'b1;
        mem_latency       = 1;
        early_valid       = 1'b0;
        for (int i = 0; i < 20 && acc_q.size() == 4; i++) begin
            if (instruction_valid) early_valid = 1'b1;
            tick();
        end
        check_value("t4_next_acc",  pick(acc_q, 4),         64'h200);
        check_value("t4_dropped",   64'(rsp_count - r0),    64'd3);
        for (int i = 0; i < 10 && !instruction_valid; i++) begin
            tick();
        end
        check_value("t4_no_early_valid", 64'(early_valid),     64'h0);
        check_value("t4_ivalid",         64'(instruction_valid), 64'h1);
        check_value("t4_pc",             instruction_pc,       64'h200);
        check_value("t4_inst",           64'(instruction),     64'hC0DE_0200);

        // Redirect coinciding with a response, then a second redirect while flushing.
        do_reset("t5");
        imem_request_ready = 1'b1;
        instruction_ready  = 1'b1;
        mem_latency        = 3;
        tick();
        tick();
        tick();
        tick();
        redirect_valid   = 1'b1;
        redirect_address = 64'h280;
        tick();
        redirect_address = 64'h300;
        tick();
        redirect_valid = 1'b0;
        check_value("t5_flush_no_req", 64'(acc_q.size()), 64'd4);
        for (int i = 0; i < 30 && deliv_q.size() < 3; i++) begin
            tick();
        end
        check_value("t5_next_acc", pick(acc_q, 4),   64'h300);
        check_value("t5_dlv0",     pick(deliv_q, 0), 64'h300);
        check_value("t5_dlv1",     pick(deliv_q, 1), 64'h304);
        check_value("t5_dlv2",     pick(deliv_q, 2), 64'h308);

        // Boot-cycle redirect is ignored; PC wraps past the top of the address space.
        do_reset("t6");
        imem_request_ready = 1'b1;
        instruction_ready  = 1'b1;
        redirect_valid     = 1'b1;
        redirect_address   = 64'h500;
        tick();
        check_value("t6_boot_redirect", imem_request_address, 64'h0);
        redirect_address = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        repeat (6) tick();
        check_value("t6_acc1",      pick(acc_q, 1),        64'hFFFF_FFFF_FFFF_FFFC);
        check_value("t6_acc_wrap",  pick(acc_q, 2),        64'h0);
        check_value("t6_dlv0",      pick(deliv_q, 0),      64'hFFFF_FFFF_FFFF_FFFC);
        check_value("t6_dlv0_inst", pick(deliv_inst_q, 0), 64'hC0DE_FFFC);
        check_value("t6_dlv1",      pick(deliv_q, 1),      64'h0);

        // Reset asserted while flushing.
        mem_latency = 6;
        tick();
        tick();
        redirect_valid   = 1'b1;
        redirect_address = 64'h400;
        tick();
        redirect_valid = 1'b0;
        check_value("t7_flush_idle", 64'(imem_request_valid), 64'h0);
        reset = 1'b0;
        tick();
        check_value("t7_req_valid", 64'(imem_request_valid), 64'h0);
        check_value("t7_ivalid",    64'(instruction_valid),  64'h0);
        check_value("t7_inst",      64'(instruction),        64'h0);
        check_value("t7_pc",        instruction_pc,          64'h0);
        reset = 1'b1;
        tick();
        check_value("t7_restart_valid", 64'(imem_request_valid), 64'h1);
        check_value("t7_restart_addr",  imem_request_address,    64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertion_count, failure_count);
        $finish;
    end

endmodule
